// File: rtl/cmpchk_pkg.sv
// Shared types for the comparator vector checker: FSM states and the
// packed comparator flag triple {eq, lt, ltu} (eq is bit 2, ltu is bit 0).
package cmpchk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    typedef struct packed {
        logic eq;
        logic lt;
        logic ltu;
    } flags_t;

    localparam int SETTLE_CNT_W = 4;

endpackage

// File: rtl/cmp_vector_checker_if.sv
// Vector stream into the checker: operands plus expected flags.
// valid/ready: a vector transfers on a rising edge where both are high; the
// source holds valid and data stable until that edge, ready never waits on valid.
interface cmp_vector_checker_if #(parameter int WIDTH = 64);

    logic             vec_valid;
    logic             vec_ready;
    logic [WIDTH-1:0] vec_op1;
    logic [WIDTH-1:0] vec_op2;
    logic             vec_eq;
    logic             vec_lt;
    logic             vec_ltu;

    modport master (
        output vec_valid, vec_op1, vec_op2, vec_eq, vec_lt, vec_ltu,
        input  vec_ready
    );

    modport slave (
        input  vec_valid, vec_op1, vec_op2, vec_eq, vec_lt, vec_ltu,
        output vec_ready
    );

endinterface

// File: rtl/cmpchk_errlog.sv
// First-error capture for the vector checker (built only with CMPCHK_ERRLOG_EN).
// Holds the first mismatching vector until reset or the next accepted start.
module cmpchk_errlog
    import cmpchk_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CNTW  = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             capture,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  flags_t           got,
    input  flags_t           exp,
    input  logic [CNTW-1:0]  idx,
    output logic [WIDTH-1:0] err_op1,
    output logic [WIDTH-1:0] err_op2,
    output logic [2:0]       err_got,
    output logic [2:0]       err_exp,
    output logic [CNTW-1:0]  err_idx
);

    logic             logged_q, logged_d;
    logic [WIDTH-1:0] op1_q, op1_d, op2_q, op2_d;
    flags_t           got_q, got_d, exp_q, exp_d;
    logic [CNTW-1:0]  idx_q, idx_d;

    always_comb begin
        logged_d = logged_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        got_d    = got_q;
        exp_d    = exp_q;
        idx_d    = idx_q;
        if (clear) begin
            logged_d = 1'b0;
            op1_d    = '0;
            op2_d    = '0;
            got_d    = '0;
            exp_d    = '0;
            idx_d    = '0;
        end else if (capture && !logged_q) begin
            logged_d = 1'b1;
            op1_d    = op1;
            op2_d    = op2;
            got_d    = got;
            exp_d    = exp;
            idx_d    = idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            logged_q <= 1'b0;
            op1_q    <= '0;
            op2_q    <= '0;
            got_q    <= '0;
            exp_q    <= '0;
            idx_q    <= '0;
        end else begin
            logged_q <= logged_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            got_q    <= got_d;
            exp_q    <= exp_d;
            idx_q    <= idx_d;
        end
    end

    assign err_op1 = op1_q;
    assign err_op2 = op2_q;
    assign err_got = got_q;
    assign err_exp = exp_q;
    assign err_idx = idx_q;

endmodule

// File: rtl/cmp_vector_checker.sv
// Streams operand vectors into an external comparator, waits SETTLE cycles and
// checks {EQ,LT,LTu} against expected flags. Define CMPCHK_ERRLOG_EN for first-error capture.
module cmp_vector_checker
    import cmpchk_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int CNTW   = 64,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [CNTW-1:0]  n_vec,
    output logic             busy,
    output logic             done,
    output logic             pass,
    cmp_vector_checker_if.slave vec,
    output logic [WIDTH-1:0] op1,
    output logic [WIDTH-1:0] op2,
    input  logic             EQ,
    input  logic             LT,
    input  logic             LTu,
    output logic [CNTW-1:0]  vec_count,
    output logic [CNTW-1:0]  err_count,
    output state_t           dbg_state
`ifdef CMPCHK_ERRLOG_EN
    ,
    output logic [WIDTH-1:0] err_op1,
    output logic [WIDTH-1:0] err_op2,
    output logic [2:0]       err_got,
    output logic [2:0]       err_exp,
    output logic [CNTW-1:0]  err_idx
`endif
);

    state_t                  state_q, state_d;
    logic [SETTLE_CNT_W-1:0] settle_q, settle_d;
    logic [WIDTH-1:0]        op1_q, op1_d, op2_q, op2_d;
    flags_t                  exp_q, exp_d;
    logic [CNTW-1:0]         n_vec_q, n_vec_d;
    logic [CNTW-1:0]         vec_count_q, vec_count_d;
    logic [CNTW-1:0]         err_count_q, err_count_d;
    logic                    ready;
    flags_t                  got;
    logic                    err;

    assign got = {EQ, LT, LTu};
    // Case inequality so an X/Z flag from the comparator counts as an error in simulation.
    assign err = (got !== exp_q);

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        exp_d       = exp_q;
        n_vec_d     = n_vec_q;
        vec_count_d = vec_count_q;
        err_count_d = err_count_q;
        ready       = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    vec_count_d = '0;
                    err_count_d = '0;
                    n_vec_d     = n_vec;
                    state_d     = (n_vec == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                ready = 1'b1;
                if (vec.vec_valid) begin
                    op1_d    = vec.vec_op1;
                    op2_d    = vec.vec_op2;
                    exp_d    = {vec.vec_eq, vec.vec_lt, vec.vec_ltu};
                    settle_d = '0;
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_q == SETTLE_CNT_W'(SETTLE - 1)) begin
                    state_d = ST_CHECK;
                end else begin
                    settle_d = settle_q + SETTLE_CNT_W'(1);
                end
            end
            ST_CHECK: begin
                vec_count_d = vec_count_q + CNTW'(1);
                if (err && (err_count_q != '1)) begin
                    err_count_d = err_count_q + CNTW'(1);
                end
                state_d = (vec_count_d == n_vec_q) ? ST_DONE : ST_LOAD;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            settle_q    <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            exp_q       <= '0;
            n_vec_q     <= '0;
            vec_count_q <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            exp_q       <= exp_d;
            n_vec_q     <= n_vec_d;
            vec_count_q <= vec_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign vec.vec_ready = ready;
    assign op1           = op1_q;
    assign op2           = op2_q;
    assign vec_count     = vec_count_q;
    assign err_count     = err_count_q;
    assign busy          = (state_q == ST_LOAD) || (state_q == ST_SETTLE) || (state_q == ST_CHECK);
    assign done          = (state_q == ST_DONE);
    assign pass          = done && (err_count_q == '0);
    assign dbg_state     = state_q;

`ifdef CMPCHK_ERRLOG_EN
    logic log_clear;
    logic log_capture;

    assign log_clear   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign log_capture = (state_q == ST_CHECK) && err;

    cmpchk_errlog #(
        .WIDTH (WIDTH),
        .CNTW  (CNTW)
    ) u_errlog (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (log_clear),
        .capture (log_capture),
        .op1     (op1_q),
        .op2     (op2_q),
        .got     (got),
        .exp     (exp_q),
        .idx     (vec_count_q),
        .err_op1 (err_op1),
        .err_op2 (err_op2),
        .err_got (err_got),
        .err_exp (err_exp),
        .err_idx (err_idx)
    );
`endif

endmodule

// File: doc/cmp_vector_checker.md
CMP_VECTOR_CHECKER -- requirements
Module: cmp_vector_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 64, the operand width driven to the comparator under test.
REQ-002 SHALL have parameter CNTW, default 64, the width of the vector and error counters.
REQ-003 SHALL have parameter SETTLE, default 1, legal range 1..15, the cycles between driving operands and sampling flags.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-006 SHALL have ports: start in 1 (run pulse); n_vec in CNTW (vectors to run); busy out 1; done out 1; pass out 1.
REQ-007 SHALL have vector stream ports: vec_valid in 1; vec_ready out 1; vec_op1 in WIDTH; vec_op2 in WIDTH; vec_eq in 1; vec_lt in 1; vec_ltu in 1 (expected flags).
REQ-008 SHALL have comparator ports: op1 out WIDTH; op2 out WIDTH; EQ in 1; LT in 1; LTu in 1.
REQ-009 SHALL have ports vec_count out CNTW and err_count out CNTW.

Function
REQ-010 SHALL implement the FSM states IDLE, LOAD, SETTLE, CHECK, DONE.
REQ-011 In IDLE or DONE, start=1 SHALL clear vec_count and err_count, latch n_vec, and go to DONE if n_vec==0, else to LOAD, on the next edge.
REQ-012 start SHALL be ignored in LOAD, SETTLE and CHECK.
REQ-013 vec_ready SHALL be 1 only in LOAD.
REQ-014 A transfer occurs only on a cycle with vec_valid&&vec_ready; on a transfer, op1/op2 SHALL register vec_op1/vec_op2, the expected flags SHALL be registered, and the FSM SHALL enter SETTLE.
REQ-015 With no transfer, LOAD SHALL hold, and op1/op2 SHALL hold their last values.
REQ-016 SETTLE SHALL last exactly SETTLE cycles, then enter CHECK.
REQ-017 In CHECK, the sampled {EQ,LT,LTu} SHALL be compared bitwise with the expected flags, and any mismatch SHALL count as an error.
REQ-018 In simulation, an X or Z on any sampled flag SHALL count as an error.
REQ-019 In CHECK, vec_count SHALL increment by 1, and err_count SHALL increment by 1 on error, saturating at all-ones.
REQ-020 From CHECK, the FSM SHALL go to DONE when the incremented vec_count equals the latched n_vec, else to LOAD.
REQ-021 Per-vector throughput SHALL be SETTLE+2 cycles when vec_valid is held high.
REQ-022 busy SHALL be 1 in LOAD, SETTLE and CHECK.
REQ-023 done SHALL be 1 only in DONE.
REQ-024 pass SHALL be done && (err_count==0).
REQ-025 DONE SHALL hold all counters until the next start.

Reset
REQ-026 reset_n=0 at a rising edge SHALL force IDLE and clear op1, op2, vec_count, err_count, busy, done, pass, vec_ready and all captured registers to 0, including mid-run.
REQ-027 A transfer coinciding with reset SHALL be discarded.

Configuration
REQ-028 Macro CMPCHK_ERRLOG_EN SHALL, when defined, add outputs err_op1 WIDTH, err_op2 WIDTH, err_got 3, err_exp 3 and err_idx CNTW, capturing the first mismatching vector and its vec_count value (pre-increment); these SHALL be cleared by reset and by start, and SHALL not update on later errors.
REQ-029 Without CMPCHK_ERRLOG_EN, those ports and registers SHALL be absent, with no other behavioural change.

Structure
REQ-030 Package cmpchk_pkg SHALL hold the FSM state enum and a packed flags struct {eq, lt, ltu}, with bit order eq=2, lt=1, ltu=0 used for err_got/err_exp.
REQ-031 First-error capture SHALL be the sub-module cmpchk_errlog, instantiated only under CMPCHK_ERRLOG_EN.

Verification
REQ-032 Reset: hold reset_n=0 for 2 cycles -> all outputs 0, vec_ready=0, busy=0.
REQ-033 Clean run, ideal 64-bit comparator, SETTLE=1, n_vec=3, vectors (5,5,exp 100), (1,2,exp 011), (FFFF_FFFF_FFFF_FFFF,1,exp 010) streamed back-to-back -> done 9 cycles after the first transfer, vec_count=3, err_count=0, pass=1.
REQ-034 Injected error: same run with the second expectation set to 000 -> err_count=1, pass=0; with CMPCHK_ERRLOG_EN: err_idx=1, err_op1=1, err_op2=2, err_got=011, err_exp=000.
REQ-035 Backpressure: n_vec=2 with vec_valid low for 4 cycles between vectors -> op1/op2 stable during gaps, vec_count=2 only after both transfers.
REQ-036 Reset mid-run: reset_n=0 during SETTLE of vector 1 -> next cycle IDLE, counters 0, and a following start with n_vec=1 completes normally.
REQ-037 Empty run: start with n_vec=0 -> done=1 and pass=1 on the next cycle, and vec_ready is never asserted.
